// File: rtl/axi_rd_decoder.sv
// AXI-Lite read-path address decoder: one manager fans out to NUM_S
// subordinates. The top address bits select the target. A FIFO of routing
// tokens returns R beats to the manager strictly in issue order. Addresses
// beyond the last subordinate are absorbed locally and answered with DECERR.
module axi_rd_decoder #(
    parameter int NUM_S           = 3,
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        axi_clk,
    input  logic                        axi_reset,
    // manager side
    input  logic [ADDR_WIDTH-1:0]       m_araddr,
    input  logic                        m_arvalid,
    output logic                        m_arready,
    output logic [DATA_WIDTH-1:0]       m_rdata,
    output logic [1:0]                  m_rresp,
    output logic                        m_rvalid,
    input  logic                        m_rready,
    // subordinate side
    output logic [ADDR_WIDTH-1:0]       s_araddr,
    output logic [NUM_S-1:0]            s_arvalid,
    input  logic [NUM_S-1:0]            s_arready,
    input  logic [NUM_S*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_S*2-1:0]          s_rresp,
    input  logic [NUM_S-1:0]            s_rvalid,
    output logic [NUM_S-1:0]            s_rready
);

    localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int T_W   = $clog2(NUM_S + 1);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    // Token value reserved for "no subordinate": the R side fabricates DECERR.
    localparam logic [T_W-1:0]   ERR_TOK   = T_W'(NUM_S);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SEL_W:0]   NUM_S_EXT = (SEL_W + 1)'(NUM_S);
    localparam logic [1:0]       RESP_DECERR = 2'b11;

    // ------------------------------------------------------------------
    // Token FIFO state
    // ------------------------------------------------------------------
    logic [T_W-1:0]   r_tok_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [T_W-1:0]   w_push_tok;
    logic [T_W-1:0]   w_head_tok;
    logic             w_head_err;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] w_sel;
    logic             w_routed;
    logic [NUM_S-1:0] w_ar_hit;
    logic [NUM_S-1:0] w_r_hit;
    logic             w_tgt_ready;

    logic [DATA_WIDTH-1:0] w_rdata_sl [NUM_S];
    logic [1:0]            w_rresp_sl [NUM_S];

    assign w_sel    = m_araddr[ADDR_WIDTH-1 -: SEL_W];
    assign w_routed = ({1'b0, w_sel} < NUM_S_EXT);

    // The count is cleared asynchronously, so it already reads empty during
    // reset. Gating with axi_reset as well keeps the R outputs quiet even if
    // the clear were ever made synchronous.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0) | axi_reset;

    assign w_head_tok = r_tok_mem[r_rptr];
    assign w_head_err = ~w_empty & (w_head_tok == ERR_TOK);

    // The address is a plain broadcast. Only the valid bits are steered.
    assign s_araddr = m_araddr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_sub
            localparam logic [SEL_W-1:0] SEL_IDX = SEL_W'(gi);
            localparam logic [T_W-1:0]   TOK_IDX = T_W'(gi);

            // AR side. Valid is built from manager valid and FIFO space only,
            // so it never waits on the subordinate's ready.
            assign w_ar_hit[gi]  = w_routed & (w_sel == SEL_IDX);
            assign s_arvalid[gi] = w_ar_hit[gi] & m_arvalid & ~w_full & ~axi_reset;

            // R side. Only the subordinate named by the FIFO head is listened
            // to. Beats from the others stay pending on their own ports.
            assign w_r_hit[gi]  = ~w_empty & (w_head_tok == TOK_IDX);
            assign s_rready[gi] = w_r_hit[gi] & m_rready;

            assign w_rdata_sl[gi] = s_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_rresp_sl[gi] = s_rresp[gi*2 +: 2];
        end
    endgenerate

    assign w_tgt_ready = |(w_ar_hit & s_arready);

    // Unmapped addresses are swallowed immediately. Mapped ones complete
    // when the chosen subordinate is ready. Nothing is accepted while full,
    // even if the head pops in the same cycle.
    assign m_arready = ~axi_reset & ~w_full & (w_routed ? w_tgt_ready : 1'b1);

    assign w_push_tok = w_routed ? T_W'(w_sel) : ERR_TOK;
    assign w_push     = m_arvalid & m_arready;

    // A DECERR head is always valid. A routed head mirrors its subordinate.
    assign m_rvalid = w_head_err | (|(w_r_hit & s_rvalid));
    assign w_pop    = m_rvalid & m_rready;

    // Return-data mux: the selected slice, fixed DECERR, or all zeros when idle.
    always_comb begin
        m_rdata = '0;
        m_rresp = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (w_r_hit[i]) begin
                m_rdata = w_rdata_sl[i];
                m_rresp = w_rresp_sl[i];
            end
        end
        if (w_head_err) begin
            m_rdata = '0;
            m_rresp = RESP_DECERR;
        end
    end

    // Token storage. It needs no reset because the pointers and count define
    // which entries are live.
    always_ff @(posedge axi_clk) begin
        if (w_push) begin
            r_tok_mem[r_wptr] <= w_push_tok;
        end
    end

    // Pointer and occupancy tracking. Reset drops every outstanding token
    // at once. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_decoder.sv
// Directed testbench for axi_rd_decoder (NUM_S=3, ADDR_WIDTH=20,
// DATA_WIDTH=16, MAX_OUTSTANDING=4). The bench drives the subordinate ports
// by hand. Inputs change on the falling edge, and outputs are checked 1 ns
// later.
module tb_axi_rd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [15:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [19:0] s_araddr;
    logic [2:0]  s_arvalid;
    logic [2:0]  s_arready;
    logic [47:0] s_rdata;
    logic [5:0]  s_rresp;
    logic [2:0]  s_rvalid;
    logic [2:0]  s_rready;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] A_S0  = 20'h0_0000;
    localparam logic [19:0] A_S1  = 20'h4_0123;
    localparam logic [19:0] A_S2  = 20'h8_0000;
    localparam logic [19:0] A_ERR = 20'hC_0000;

    axi_rd_decoder #(
        .NUM_S(3), .ADDR_WIDTH(20), .DATA_WIDTH(16), .MAX_OUTSTANDING(4)
    ) dut (
        .axi_clk   (clk),
        .axi_reset (rst),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 clk = ~clk;

    task automatic set_sub(input int idx, input logic [15:0] d, input logic [1:0] r);
        s_rdata[idx*16 +: 16] = d;
        s_rresp[idx*2 +: 2]   = r;
    endtask

    // An empty FIFO ignores every subordinate even when all are valid.
    task automatic test_empty(input string tag);
        logic [2:0] sv_save;
        logic       rr_save;
        sv_save  = s_rvalid;
        rr_save  = m_rready;
        s_rvalid = 3'b111;
        m_rready = 1'b1;
        #1;
        checks++;
        if (m_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty_rvalid got %b want 0", tag, m_rvalid);
        end
        checks++;
        if (s_rready !== 3'b000) begin
            errors++;
            $display("FAIL %s_empty_srready got %b want 000", tag, s_rready);
        end
        s_rvalid = sv_save;
        m_rready = rr_save;
    endtask

    task automatic test_reset();
        m_araddr  = A_S1;
        m_arvalid = 1'b1;
        m_rready  = 1'b0;
        s_arready = 3'b111;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rvalid  = 3'b111;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (m_arready !== 1'b0) begin
            errors++; $display("FAIL reset_arready got %b want 0", m_arready);
        end
        checks++;
        if (s_arvalid !== 3'b000) begin
            errors++; $display("FAIL reset_sarvalid got %b want 000", s_arvalid);
        end
        checks++;
        if (m_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid got %b want 0", m_rvalid);
        end
        checks++;
        if (s_araddr !== A_S1) begin
            errors++; $display("FAIL reset_saraddr got %h want %h", s_araddr, A_S1);
        end
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        m_arvalid = 1'b0;
        s_rvalid  = 3'b000;
        m_araddr  = A_S0;
        #1;
        checks++;
        if (m_arready !== 1'b1) begin
            errors++; $display("FAIL post_reset_arready got %b want 1", m_arready);
        end
        test_empty("post_reset");
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m_araddr  = A_S1;
        m_arvalid = 1'b1;
        m_rready  = 1'b1;
        #1;
        checks++;
        if (s_arvalid !== 3'b010) begin
            errors++; $display("FAIL single_sarvalid got %b want 010", s_arvalid);
        end
        checks++;
        if (m_arready !== 1'b1) begin
            errors++; $display("FAIL single_arready got %b want 1", m_arready);
        end
        @(negedge clk);
        m_arvalid = 1'b0;
        #1;
        checks++;
        if (s_arvalid !== 3'b000) begin
            errors++; $display("FAIL single_sarvalid_after got %b want 000", s_arvalid);
        end
        checks++;
        if (m_rvalid !== 1'b0 || s_rready !== 3'b010) begin
            errors++;
            $display("FAIL single_wait got rvalid=%b srready=%b want 0/010", m_rvalid, s_rready);
        end
        repeat (2) @(negedge clk);
        set_sub(1, 16'hBEEF, 2'b00);
        s_rvalid = 3'b010;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_rdata !== 16'hBEEF || m_rresp !== 2'b00) begin
            errors++;
            $display("FAIL single_resp got v=%b d=%h r=%b want 1/BEEF/00", m_rvalid, m_rdata, m_rresp);
        end
        @(negedge clk);
        s_rvalid = 3'b000;
        m_rready = 1'b0;
        test_empty("single");
        $display("test_single_read done");
    endtask

    task automatic test_out_of_order();
        @(negedge clk);
        m_araddr  = A_S0;
        m_arvalid = 1'b1;
        m_rready  = 1'b1;
        @(negedge clk);
        m_araddr  = A_S2;
        @(negedge clk);
        m_arvalid = 1'b0;
        set_sub(2, 16'h2222, 2'b01);
        s_rvalid  = 3'b100;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (m_rvalid !== 1'b0 || s_rready !== 3'b001) begin
                errors++;
                $display("FAIL ooo_hold%0d got rvalid=%b srready=%b want 0/001", c, m_rvalid, s_rready);
            end
            @(negedge clk);
        end
        set_sub(0, 16'h1111, 2'b00);
        s_rvalid = 3'b101;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_rdata !== 16'h1111 || s_rready !== 3'b001) begin
            errors++;
            $display("FAIL ooo_first got v=%b d=%h srready=%b want 1/1111/001", m_rvalid, m_rdata, s_rready);
        end
        @(negedge clk);
        s_rvalid = 3'b100;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_rdata !== 16'h2222 || m_rresp !== 2'b01 || s_rready !== 3'b100) begin
            errors++;
            $display("FAIL ooo_second got v=%b d=%h r=%b srready=%b want 1/2222/01/100",
                     m_rvalid, m_rdata, m_rresp, s_rready);
        end
        @(negedge clk);
        s_rvalid = 3'b000;
        m_rready = 1'b0;
        test_empty("ooo");
        $display("test_out_of_order done");
    endtask

    task automatic test_decode_error();
        @(negedge clk);
        m_araddr  = A_ERR;
        m_arvalid = 1'b1;
        m_rready  = 1'b0;
        s_arready = 3'b000;
        #1;
        checks++;
        if (s_arvalid !== 3'b000 || m_arready !== 1'b1) begin
            errors++;
            $display("FAIL decerr_ar got sarvalid=%b arready=%b want 000/1", s_arvalid, m_arready);
        end
        checks++;
        if (m_rvalid !== 1'b0) begin
            errors++; $display("FAIL decerr_early_rvalid got %b want 0", m_rvalid);
        end
        @(negedge clk);
        m_arvalid = 1'b0;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_rresp !== 2'b11 || m_rdata !== 16'h0000 || s_rready !== 3'b000) begin
            errors++;
            $display("FAIL decerr_resp got v=%b r=%b d=%h srready=%b want 1/11/0000/000",
                     m_rvalid, m_rresp, m_rdata, s_rready);
        end
        m_rready = 1'b1;
        @(negedge clk);
        m_rready  = 1'b0;
        s_arready = 3'b111;
        test_empty("decerr");
        $display("test_decode_error done");
    endtask

    task automatic test_full_fifo();
        logic [19:0] addrs [4];
        logic [15:0] exp_d [4];
        addrs[0] = A_S0; addrs[1] = A_S1; addrs[2] = A_S2; addrs[3] = A_S0;
        m_rready = 1'b0;
        s_rvalid = 3'b000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_araddr  = addrs[k];
            m_arvalid = 1'b1;
            #1;
            checks++;
            if (m_arready !== 1'b1) begin
                errors++; $display("FAIL full_fill%0d arready got %b want 1", k, m_arready);
            end
        end
        @(negedge clk);
        m_araddr = A_S1;
        #1;
        checks++;
        if (m_arready !== 1'b0 || s_arvalid !== 3'b000) begin
            errors++;
            $display("FAIL full_block got arready=%b sarvalid=%b want 0/000", m_arready, s_arvalid);
        end
        @(negedge clk);
        set_sub(0, 16'hA0A0, 2'b00);
        s_rvalid = 3'b001;
        m_rready = 1'b1;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_rdata !== 16'hA0A0 || m_arready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle got v=%b d=%h arready=%b want 1/A0A0/0", m_rvalid, m_rdata, m_arready);
        end
        @(negedge clk);
        s_rvalid = 3'b000;
        m_rready = 1'b0;
        #1;
        checks++;
        if (m_arready !== 1'b1 || s_arvalid !== 3'b010) begin
            errors++;
            $display("FAIL full_resume got arready=%b sarvalid=%b want 1/010", m_arready, s_arvalid);
        end
        @(negedge clk);
        m_araddr = A_S2;
        #1;
        checks++;
        if (m_arready !== 1'b0) begin
            errors++; $display("FAIL full_again arready got %b want 0", m_arready);
        end
        m_arvalid = 1'b0;
        set_sub(0, 16'h0A0A, 2'b00);
        set_sub(1, 16'h1B1B, 2'b00);
        set_sub(2, 16'h2C2C, 2'b00);
        exp_d[0] = 16'h1B1B; exp_d[1] = 16'h2C2C; exp_d[2] = 16'h0A0A; exp_d[3] = 16'h1B1B;
        s_rvalid = 3'b111;
        m_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (m_rvalid !== 1'b1 || m_rdata !== exp_d[k]) begin
                errors++;
                $display("FAIL full_drain%0d got v=%b d=%h want 1/%h", k, m_rvalid, m_rdata, exp_d[k]);
            end
            @(negedge clk);
        end
        s_rvalid = 3'b000;
        m_rready = 1'b0;
        test_empty("full");
        $display("test_full_fifo done");
    endtask

    task automatic test_pointer_wrap();
        logic [19:0] addrs [4];
        int          sub_of [10];
        logic [15:0] exp_d;
        logic [1:0]  exp_r;
        addrs[0] = A_S0; addrs[1] = A_S1; addrs[2] = A_S2; addrs[3] = A_ERR;
        m_rready = 1'b1;
        s_rvalid = 3'b111;
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            if (j < 10) begin
                m_araddr  = addrs[j % 4];
                m_arvalid = 1'b1;
                sub_of[j] = j % 4;
            end else begin
                m_arvalid = 1'b0;
            end
            // Each slice carries {sub, cycle} so a wrong slice or stale beat shows.
            set_sub(0, {8'h00, 8'(j)}, 2'b00);
            set_sub(1, {8'h11, 8'(j)}, 2'b01);
            set_sub(2, {8'h22, 8'(j)}, 2'b10);
            #1;
            if (j > 0) begin
                case (sub_of[j-1])
                    0:       begin exp_d = {8'h00, 8'(j)}; exp_r = 2'b00; end
                    1:       begin exp_d = {8'h11, 8'(j)}; exp_r = 2'b01; end
                    2:       begin exp_d = {8'h22, 8'(j)}; exp_r = 2'b10; end
                    default: begin exp_d = 16'h0000;        exp_r = 2'b11; end
                endcase
                checks++;
                if (m_rvalid !== 1'b1 || m_rdata !== exp_d || m_rresp !== exp_r) begin
                    errors++;
                    $display("FAIL wrap_resp%0d got v=%b d=%h r=%b want 1/%h/%b",
                             j - 1, m_rvalid, m_rdata, m_rresp, exp_d, exp_r);
                end
            end
            if (j < 10) begin
                checks++;
                if (m_arready !== 1'b1) begin
                    errors++; $display("FAIL wrap_arready%0d got %b want 1", j, m_arready);
                end
            end
        end
        @(negedge clk);
        s_rvalid = 3'b000;
        m_rready = 1'b0;
        test_empty("wrap");
        $display("test_pointer_wrap done");
    endtask

    task automatic test_async_reset();
        logic [19:0] addrs [3];
        addrs[0] = A_S0; addrs[1] = A_S1; addrs[2] = A_S2;
        m_rready = 1'b0;
        set_sub(0, 16'h7777, 2'b00);
        s_rvalid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_araddr  = addrs[k];
            m_arvalid = 1'b1;
        end
        @(negedge clk);
        m_araddr = A_S0;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_arready !== 1'b1) begin
            errors++;
            $display("FAIL areset_before got rvalid=%b arready=%b want 1/1", m_rvalid, m_arready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_rvalid !== 1'b0 || m_arready !== 1'b0 || s_arvalid !== 3'b000 || s_rready !== 3'b000) begin
            errors++;
            $display("FAIL areset_during got rvalid=%b arready=%b sarvalid=%b srready=%b want 0/0/000/000",
                     m_rvalid, m_arready, s_arvalid, s_rready);
        end
        @(negedge clk);
        rst       = 1'b0;
        m_arvalid = 1'b0;
        s_rvalid  = 3'b000;
        test_empty("areset");
        @(negedge clk);
        m_araddr  = A_S2;
        m_arvalid = 1'b1;
        m_rready  = 1'b1;
        #1;
        checks++;
        if (m_arready !== 1'b1 || s_arvalid !== 3'b100) begin
            errors++;
            $display("FAIL areset_newar got arready=%b sarvalid=%b want 1/100", m_arready, s_arvalid);
        end
        @(negedge clk);
        m_arvalid = 1'b0;
        set_sub(2, 16'h5A5A, 2'b00);
        s_rvalid = 3'b100;
        #1;
        checks++;
        if (m_rvalid !== 1'b1 || m_rdata !== 16'h5A5A || m_rresp !== 2'b00) begin
            errors++;
            $display("FAIL areset_newr got v=%b d=%h r=%b want 1/5A5A/00", m_rvalid, m_rdata, m_rresp);
        end
        @(negedge clk);
        s_rvalid = 3'b000;
        m_rready = 1'b0;
        test_empty("areset_after");
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_out_of_order();
        test_decode_error();
        test_full_fifo();
        test_pointer_wrap();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_decoder.md
Name: axi_rd_decoder

Overview:
- Read-path AXI-Lite address decoder: one manager on the input, NUM_S subordinates on the output.
- It is the fan-out counterpart of the many-manager arbiter that feeds a shared subordinate. It sits between a manager (or an arbiter's subordinate port) and several SRAM/peripheral subordinates.
- It routes each AR to the subordinate selected by the top address bits. It returns R beats to the manager strictly in issue order, using an internal FIFO of routing tokens.
- Addresses that decode to no subordinate are accepted internally and answered with DECERR.

Parameters:
- NUM_S, 3: number of subordinates.
- ADDR_WIDTH, 20: address width.
- DATA_WIDTH, 16: read data width.
- MAX_OUTSTANDING, 4: token FIFO depth; must be a power of 2 and at least 2.
- Derived: SEL_W = $clog2(NUM_S) (minimum 1). Token width T_W = $clog2(NUM_S+1).

Ports:
- axi_clk  in  1  clock.
- axi_reset  in  1  asynchronous, active-high reset.
- m_araddr  in  ADDR_WIDTH  manager read address.
- m_arvalid  in  1  manager AR valid.
- m_arready  out  1  AR accepted when high together with m_arvalid.
- m_rdata  out  DATA_WIDTH  read data to manager.
- m_rresp  out  2  response code to manager.
- m_rvalid  out  1  R valid to manager.
- m_rready  in  1  manager R ready.
- s_araddr  out  ADDR_WIDTH  address broadcast to all subordinates (equals m_araddr).
- s_arvalid  out  NUM_S  one-hot AR valid per subordinate.
- s_arready  in  NUM_S  per-subordinate AR ready.
- s_rdata  in  NUM_S*DATA_WIDTH  packed read data; subordinate i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_rresp  in  NUM_S*2  packed response codes.
- s_rvalid  in  NUM_S  per-subordinate R valid.
- s_rready  out  NUM_S  per-subordinate R ready.

Behaviour:
- Decode:
  - sel = m_araddr[ADDR_WIDTH-1 -: SEL_W].
  - sel < NUM_S: routed; token = sel.
  - sel >= NUM_S: decode error; token = NUM_S.
- AR path (combinational through the block; no added latency):
  - full = (count == MAX_OUTSTANDING).
  - Routed: s_arvalid[sel] = m_arvalid & ~full; other s_arvalid bits are 0; m_arready = ~full & s_arready[sel].
  - Error: all s_arvalid are 0; m_arready = ~full.
  - s_arvalid must not depend on any s_arready.
- Token FIFO:
  - Push the token on m_arvalid & m_arready. Pop on m_rvalid & m_rready.
  - count is updated with push and pop evaluated independently. Simultaneous push and pop leaves count unchanged.
  - When full, m_arready is 0 even if a pop occurs in the same cycle; acceptance resumes the following cycle.
  - Read and write pointers wrap modulo MAX_OUTSTANDING.
- R path, with head token h (combinational from the registered FIFO head):
  - Empty FIFO: m_rvalid = 0, all s_rready = 0, m_rdata = 0, m_rresp = 0.
  - h < NUM_S: m_rvalid = s_rvalid[h]; m_rdata and m_rresp are taken from slice h; s_rready[h] = m_rready; other s_rready = 0.
  - h == NUM_S: m_rvalid = 1, m_rdata = 0, m_rresp = 2'b11 (DECERR); all s_rready = 0.
  - s_rvalid from any subordinate other than the head is ignored. It stays pending, and ordering is preserved.
- Latency:
  - Routed response: 0 added cycles.
  - Decode error: m_rvalid rises no earlier than the cycle after AR acceptance (token registered), and as soon as that token reaches the head.
- Reset:
  - axi_reset asserted clears pointers and count immediately (async); deassertion is used synchronously.
  - While axi_reset is high: m_arready = 0, s_arvalid = 0, m_rvalid = 0, s_rready = 0.
  - Reset mid-transaction drops all outstanding tokens. Subordinates must be reset together with this block.
- Protocol: AR or R valid, once asserted by this block, must be held until the handshake completes. This is guaranteed because the full and head state changes only on handshakes.

Test Plan:
- Single read to sub 1:
  - Stimulus: araddr=0x4_0123 (sel=1). Sub 1 returns rdata=0xBEEF, rresp=0 three cycles later.
  - Required: s_arvalid=3'b010 for exactly the handshake cycle; m_rdata=0xBEEF, m_rresp=0; FIFO empty afterwards.
- Out-of-order subordinate return:
  - Stimulus: AR to sub 0 then sub 2; sub 2 asserts rvalid first.
  - Required: s_rready[2] held at 0 until the sub 0 beat completes; manager sees the sub 0 data, then the sub 2 data.
- Decode error:
  - Stimulus: araddr=0xC_0000 (sel=3, NUM_S=3).
  - Required: no s_arvalid; m_arready=1; next cycle m_rvalid=1, m_rresp=2'b11, m_rdata=0.
- Full FIFO:
  - Stimulus: 4 ARs accepted with m_rready=0.
  - Required: fifth AR sees m_arready=0, including in the cycle of the first pop. It is accepted the cycle after that pop; count returns to 4.
- Pointer wrap: 10 back-to-back reads rotating sub 0/1/2/error with m_rready=1 -> all responses in issue order with correct data and rresp.
- Async reset:
  - Stimulus: assert axi_reset mid-clock with 3 outstanding.
  - Required: m_rvalid and m_arready drop to 0 immediately; after release, the FIFO is empty and a new read completes normally.
